// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of the 64x64 data memory.
// One request in flight: EA range check, one-cycle access, held response.
module load_store_unit #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 64,
   parameter int OFF_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [DATA_W-1:0] req_base,
   input  logic [OFF_W-1:0]  req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_fault,
   output logic [ADDR_W-1:0] d_mem_addr,
   output logic              d_mem_we,
   output logic [DATA_W-1:0] d_mem_data_in,
   input  logic [DATA_W-1:0] d_mem_data_out
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              fault_q, fault_d;
   logic [DATA_W-1:0] ea;
   logic              ea_fault;

   // effective address wraps modulo 2^DATA_W; any upper bit set is out of range
   assign ea = req_base
             + {{(DATA_W-OFF_W){req_offset[OFF_W-1]}}, req_offset};
   assign ea_fault = |ea[DATA_W-1:ADDR_W];

   // next-state: accept in IDLE, one access cycle, hold response until taken
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               rdata_d = '0;
               if (ea_fault) begin
                  fault_d = 1'b1;
                  state_d = RESP;
               end else begin
                  fault_d = 1'b0;
                  addr_d  = ea[ADDR_W-1:0];
                  wdata_d = req_wdata;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            rdata_d = we_q ? '0 : d_mem_data_out;
            fault_d = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign rsp_valid     = (state_q == RESP);
   assign rsp_rdata     = rdata_q;
   assign rsp_fault     = fault_q;
   assign d_mem_addr    = addr_q;
   assign d_mem_data_in = wdata_q;
   // rst_n gate keeps a reset during ACCESS from writing memory
   assign d_mem_we      = (state_q == ACCESS) & we_q & rst_n;

endmodule
